sfr_access_arbiter: RTL
=======================

SFR_ACCESS_ARBITER -- requirements
Module: sfr_access_arbiter

Interface
REQ-001 Parameter SFR_WIDTH, default 32, data width of the SFR port and requester data.
REQ-002 Parameter SFR_ADDR_WIDTH, default 8, SFR word-address width.
REQ-003 sys_clk  in  1  single system clock; all state on rising edge.
REQ-004 sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 sys_clk_en  in  1  clock enable; all state advances only when high.
REQ-006 req  in  2  access request per requester (bit0 = CPU, bit1 = debug).
REQ-007 req_wen  in  2  per-requester write (1) / read (0) select.
REQ-008 req_addr  in  2*SFR_ADDR_WIDTH  per-requester address; requester n at slice [n*AW +: AW].
REQ-009 req_wdata  in  2*SFR_WIDTH  per-requester write data, sliced like req_addr.
REQ-010 gnt  out  2  one-hot grant pulse.
REQ-011 rvalid  out  2  one-hot completion pulse.
REQ-012 rdata  out  SFR_WIDTH  read data, valid only while rvalid is nonzero.
REQ-013 sfr_wen  out  1  SFR write strobe.
REQ-014 sfr_addr  out  SFR_ADDR_WIDTH  SFR address.
REQ-015 sfr_din  out  SFR_WIDTH  SFR write data.
REQ-016 sfr_dout  in  SFR_WIDTH  SFR read data, combinational from sfr_addr.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; every transition requires sys_clk_en=1; with sys_clk_en=0 all registers and outputs hold.
REQ-018 IDLE: if req!=0, latch winner index, its req_wen/req_addr/req_wdata, and go to ACCESS; otherwise stay.
REQ-019 ACCESS (exactly one cycle): sfr_addr/sfr_din = latched values; sfr_wen = latched wen AND sys_clk_en; gnt[winner]=1; capture sfr_dout into the rdata register; go to RESP.
REQ-020 RESP (exactly one cycle): rvalid[winner]=1 for both reads and writes; rdata = captured value for a read, 0 for a write; go to IDLE.
REQ-021 Latency with sys_clk_en=1: req high in IDLE at cycle N -> gnt at N+1 -> rvalid at N+2; maximum throughput is one access per 3 cycles.
REQ-022 Requesters hold req/wen/addr/wdata stable until gnt; req still high in the cycle after RESP starts a new arbitration.
REQ-023 Requests changing during ACCESS or RESP are ignored; the latched transaction completes unchanged.
REQ-024 Outside ACCESS: sfr_wen=0, sfr_addr=0, sfr_din=0, gnt=0; outside RESP: rvalid=0, rdata=0.
REQ-025 Arbitration policy for simultaneous requests is set by REQ-029/REQ-030; a single request always wins.

Reset
REQ-026 On sys_rst_n=0, asynchronously: state=IDLE; gnt, rvalid, rdata, sfr_wen, sfr_addr, sfr_din = 0; latched transaction cleared; last-grant pointer = 1.
REQ-027 Reset asserted during ACCESS or RESP aborts the transaction: no further sfr_wen, gnt or rvalid for it.
REQ-028 After release, first arbitration happens on the first enabled edge with req!=0.

Configuration
REQ-029 SFR_ARB_ROUND_ROBIN_EN defined: on req=2'b11, grant goes to the requester other than the last-grant pointer; pointer updates on each entry to ACCESS.
REQ-030 SFR_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins on req=2'b11; the pointer logic is omitted.

Verification
REQ-031 req=2'b01, wen=1, addr0=0x10, wdata0=0xDEADBEEF -> gnt=2'b01 at N+1 with sfr_wen=1, sfr_addr=0x10, sfr_din=0xDEADBEEF; rvalid=2'b01, rdata=0 at N+2.
REQ-032 req=2'b10 read, addr1=0x04, sfr_dout=0x12345678 -> gnt=2'b10 at N+1, sfr_wen=0; rvalid=2'b10, rdata=0x12345678 at N+2.
REQ-033 req=2'b11 held for 4 transactions -> with SFR_ARB_ROUND_ROBIN_EN, grant order 0,1,0,1; without it, 0,0,0,0.
REQ-034 sys_clk_en=0 for 3 cycles while in ACCESS -> state, gnt, sfr_addr frozen, sfr_wen=0; on re-enable a single write pulse occurs and RESP follows.
REQ-035 sys_rst_n asserted while in ACCESS -> all outputs 0 immediately; after release with req=0, no rvalid ever appears.

Source files
------------

// File: rtl/sfr_access_arbiter.sv
// Two-requester (CPU / debug) arbiter for a single-ported SFR bank: IDLE -> ACCESS -> RESP.
// Define SFR_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed priority (CPU wins).
module sfr_access_arbiter #(
    parameter int SFR_WIDTH      = 32,
    parameter int SFR_ADDR_WIDTH = 8
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        sys_clk_en,
    input  logic [1:0]                  req,
    input  logic [1:0]                  req_wen,
    input  logic [2*SFR_ADDR_WIDTH-1:0] req_addr,
    input  logic [2*SFR_WIDTH-1:0]      req_wdata,
    output logic [1:0]                  gnt,
    output logic [1:0]                  rvalid,
    output logic [SFR_WIDTH-1:0]        rdata,
    output logic                        sfr_wen,
    output logic [SFR_ADDR_WIDTH-1:0]   sfr_addr,
    output logic [SFR_WIDTH-1:0]        sfr_din,
    input  logic [SFR_WIDTH-1:0]        sfr_dout,
    output logic [1:0]                  state_dbg
);

    // Handshake: a requester holds req/wen/addr/wdata stable until its gnt pulse;
    // the access completes with a one-cycle rvalid pulse two enabled cycles after acceptance.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t                      state, state_next;
    logic                        win_q, wen_q, win_next;
    logic [SFR_ADDR_WIDTH-1:0]   addr_q;
    logic [SFR_WIDTH-1:0]        wdata_q, rdata_q;
    logic                        accept;

    assign accept    = sys_clk_en && (state == IDLE) && (req != 2'b00);
    assign state_dbg = state;

`ifdef SFR_ARB_ROUND_ROBIN_EN
    logic last_q;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        win_next = req[1];
        if (req == 2'b11) win_next = ~last_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  last_q <= 1'b1;
        else if (accept) last_q <= win_next;
    end
`else
    always_comb win_next = ~req[0];
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)      state <= IDLE;
        else if (sys_clk_en) state <= state_next;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            win_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            win_q   <= win_next;
            wen_q   <= win_next ? req_wen[1] : req_wen[0];
            addr_q  <= win_next ? req_addr[2*SFR_ADDR_WIDTH-1:SFR_ADDR_WIDTH]
                                : req_addr[SFR_ADDR_WIDTH-1:0];
            wdata_q <= win_next ? req_wdata[2*SFR_WIDTH-1:SFR_WIDTH]
                                : req_wdata[SFR_WIDTH-1:0];
        end
    end

    // Writes report zero read data, so store zero rather than whatever the SFR drives.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            rdata_q <= '0;
        else if (sys_clk_en && state == ACCESS)
            rdata_q <= wen_q ? '0 : sfr_dout;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req != 2'b00) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt      = 2'b00;
        rvalid   = 2'b00;
        rdata    = '0;
        sfr_wen  = 1'b0;
        sfr_addr = '0;
        sfr_din  = '0;
        if (state == ACCESS) begin
            gnt      = win_q ? 2'b10 : 2'b01;
            sfr_wen  = wen_q & sys_clk_en;
            sfr_addr = addr_q;
            sfr_din  = wdata_q;
        end else if (state == RESP) begin
            rvalid = win_q ? 2'b10 : 2'b01;
            rdata  = rdata_q;
        end
    end

endmodule
